// File: rtl/id_pkg.sv
// id_pkg: opcode, funct and immediate-type definitions shared by the RV32I decode stage
package id_pkg;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SR    = 3'b101;
  localparam logic [6:0] F7_0     = 7'h00;
  localparam logic [6:0] F7_ALT   = 7'h20;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: priority forwarding mux for one source operand (index 0 wins, x0 and unused read as 0)
module id_fwd_mux #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3
) (
  input  logic                 used_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [XLEN-1:0]      rdata_i,
  input  logic [NFWD-1:0]      fwd_we_i,
  input  logic [NFWD*AW-1:0]   fwd_waddr_i,
  input  logic [NFWD*XLEN-1:0] fwd_wdata_i,
  output logic [XLEN-1:0]      data_o
);
  always_comb begin
    data_o = rdata_i;
    for (int i = NFWD - 1; i >= 0; i--)
      if (fwd_we_i[i] && fwd_waddr_i[i*AW +: AW] == addr_i) data_o = fwd_wdata_i[i*XLEN +: XLEN];
    if (!used_i || addr_i == '0) data_o = '0;
  end
endmodule

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: RV32I decode with operand forwarding, load-use stall and ID/EX register
module id_stage_fwd
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [XLEN-1:0]      if_pc,
  input  logic [31:0]          if_inst,
  output logic                 id_ready,
  output logic [AW-1:0]        reg1_raddr,
  input  logic [XLEN-1:0]      reg1_rdata,
  output logic [AW-1:0]        reg2_raddr,
  input  logic [XLEN-1:0]      reg2_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [31:0]          ex_inst,
  output logic [XLEN-1:0]      ex_reg1,
  output logic [XLEN-1:0]      ex_reg2,
  output logic [XLEN-1:0]      ex_imm,
  output logic [AW-1:0]        ex_waddr,
  output logic                 ex_we,
  output logic                 ex_is_load,
  output logic                 ex_illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic u1, u2, we, ld, ill, hazard, advance, take;
  imm_t it;
  logic [31:0] imm32;
  logic [XLEN-1:0] op1, op2;
  logic valid_q, we_q, ld_q, ill_q;
  logic [XLEN-1:0] pc_q, r1_q, r2_q, imm_q;
  logic [31:0] inst_q;
  logic [AW-1:0] waddr_q;
  assign opc = if_inst[6:0];
  assign f3 = if_inst[14:12];
  assign f7 = if_inst[31:25];
  assign reg1_raddr = AW'(if_inst[19:15]);
  assign reg2_raddr = AW'(if_inst[24:20]);
  always_comb begin
    u1 = 1'b0;
    u2 = 1'b0;
    we = 1'b0;
    ld = 1'b0;
    ill = 1'b0;
    it = IMM_NONE;
    case (opc)
      OP_R: begin
        u1 = 1'b1;
        u2 = 1'b1;
        we = 1'b1;
        ill = !(f7 == F7_0 || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      OP_I: begin
        u1 = 1'b1;
        we = 1'b1;
        it = (f3 == F3_SLL || f3 == F3_SR) ? IMM_SH : IMM_I;
        ill = f3 == F3_SLL ? f7 != F7_0 : f3 == F3_SR ? !(f7 == F7_0 || f7 == F7_ALT) : 1'b0;
      end
      OP_L: begin
        u1 = 1'b1;
        we = 1'b1;
        ld = 1'b1;
        it = IMM_I;
        ill = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      OP_S: begin
        u1 = 1'b1;
        u2 = 1'b1;
        it = IMM_S;
        ill = f3 > 3'b010;
      end
      OP_B: begin
        u1 = 1'b1;
        u2 = 1'b1;
        it = IMM_B;
        ill = f3 == 3'b010 || f3 == 3'b011;
      end
      OP_LUI, OP_AUIPC: begin
        we = 1'b1;
        it = IMM_U;
      end
      OP_JAL: begin
        we = 1'b1;
        it = IMM_J;
      end
      OP_JALR: begin
        u1 = 1'b1;
        we = 1'b1;
        it = IMM_I;
        ill = f3 != F3_ADD;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      u1 = 1'b0;
      u2 = 1'b0;
      we = 1'b0;
      ld = 1'b0;
      it = IMM_NONE;
    end
  end
  always_comb
    imm32 = it == IMM_I  ? {{20{if_inst[31]}}, if_inst[31:20]} :
            it == IMM_SH ? {27'b0, if_inst[24:20]} :
            it == IMM_S  ? {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]} :
            it == IMM_B  ? {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0} :
            it == IMM_U  ? {if_inst[31:12], 12'b0} :
            it == IMM_J  ? {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0} :
            32'b0;
  id_fwd_mux #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_fwd1 (
    .used_i(u1), .addr_i(reg1_raddr), .rdata_i(reg1_rdata), .fwd_we_i(fwd_we),
    .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata), .data_o(op1)
  );
  id_fwd_mux #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_fwd2 (
    .used_i(u2), .addr_i(reg2_raddr), .rdata_i(reg2_rdata), .fwd_we_i(fwd_we),
    .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata), .data_o(op2)
  );
  assign hazard = if_valid && valid_q && ld_q && we_q && waddr_q != '0 &&
                  ((u1 && reg1_raddr == waddr_q) || (u2 && reg2_raddr == waddr_q));
  assign advance = !valid_q || ex_ready;
  assign id_ready = advance && !hazard;
  assign take = if_valid && id_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q <= '0;
      inst_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      imm_q <= '0;
      waddr_q <= '0;
      we_q <= 1'b0;
      ld_q <= 1'b0;
      ill_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      we_q <= 1'b0;
    end else if (advance) begin
      valid_q <= take;
      if (take) begin
        pc_q <= if_pc;
        inst_q <= if_inst;
        r1_q <= op1;
        r2_q <= op2;
        imm_q <= XLEN'($signed(imm32));
        waddr_q <= AW'(if_inst[11:7]);
        we_q <= we;
        ld_q <= ld;
        ill_q <= ill;
      end else if (hazard) we_q <= 1'b0;
    end
  end
  assign ex_valid = valid_q;
  assign ex_pc = pc_q;
  assign ex_inst = inst_q;
  assign ex_reg1 = r1_q;
  assign ex_reg2 = r2_q;
  assign ex_imm = imm_q;
  assign ex_waddr = waddr_q;
  assign ex_we = we_q;
  assign ex_is_load = ld_q;
  assign ex_illegal = ill_q;
endmodule

// File: tb/tb_id_stage_fwd.sv
// tb_id_stage_fwd: directed and randomized checks of id_stage_fwd against a behavioural model
module tb_id_stage_fwd;
  logic clk = 1'b0, rst, if_valid, id_ready, flush, ex_ready, ex_valid, ex_we, ex_is_load, ex_illegal;
  logic [31:0] if_pc, if_inst, reg1_rdata, reg2_rdata, ex_pc, ex_inst, ex_reg1, ex_reg2, ex_imm;
  logic [4:0] reg1_raddr, reg2_raddr, ex_waddr;
  logic [2:0] fwd_we;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  int n_tests = 0, n_fail = 0;
  typedef struct packed {logic u1, u2, we, ld, ill; logic [31:0] imm;} dec_t;
  logic m_valid = 1'b0, m_known = 1'b0, m_we, m_ld, m_ill;
  logic [31:0] m_pc, m_inst, m_r1, m_r2, m_imm;
  logic [4:0] m_waddr;
  always #5 clk = ~clk;
  id_stage_fwd dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready),
    .reg1_raddr(reg1_raddr), .reg1_rdata(reg1_rdata), .reg2_raddr(reg2_raddr), .reg2_rdata(reg2_rdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_imm(ex_imm), .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    int op, f3, f7;
    logic legal;
    logic signed [31:0] s;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    s = $signed(w);
    d = '0;
    legal = 1'b1;
    case (op)
      'h33: begin legal = f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)); d.u1 = 1; d.u2 = 1; d.we = 1; end
      'h13: begin
        legal = f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 32) : 1'b1;
        d.u1 = 1; d.we = 1;
        d.imm = (f3 == 1 || f3 == 5) ? {27'b0, w[24:20]} : 32'(s >>> 20);
      end
      'h03: begin legal = f3 inside {0, 1, 2, 4, 5}; d.u1 = 1; d.we = 1; d.ld = 1; d.imm = 32'(s >>> 20); end
      'h23: begin legal = f3 < 3; d.u1 = 1; d.u2 = 1; d.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]); end
      'h63: begin
        legal = !(f3 inside {2, 3}); d.u1 = 1; d.u2 = 1;
        d.imm = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      'h37, 'h17: begin d.we = 1; d.imm = w & 32'hFFFF_F000; end
      'h6f: begin
        d.we = 1;
        d.imm = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      'h67: begin legal = f3 == 0; d.u1 = 1; d.we = 1; d.imm = 32'(s >>> 20); end
      default: legal = 1'b0;
    endcase
    if (!legal) d = '0;
    d.ill = !legal;
    return d;
  endfunction
  function automatic logic [31:0] ref_op(input logic used, input logic [4:0] a, input logic [31:0] rd);
    if (!used || a == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (fwd_we[i] && fwd_waddr[i*5 +: 5] == a) return fwd_wdata[i*32 +: 32];
    return rd;
  endfunction
  task automatic cycle();
    dec_t d;
    logic adv, hz, take;
    logic [31:0] r1, r2;
    d = ref_dec(if_inst);
    #1;
    adv = !m_valid || ex_ready;
    hz = if_valid && m_valid && m_ld && m_we && m_waddr != 0 &&
         ((d.u1 && if_inst[19:15] == m_waddr) || (d.u2 && if_inst[24:20] == m_waddr));
    take = if_valid && adv && !hz;
    r1 = ref_op(d.u1, if_inst[19:15], reg1_rdata);
    r2 = ref_op(d.u2, if_inst[24:20], reg2_rdata);
    chk("id_ready", 32'(id_ready), 32'(adv && !hz));
    chk("reg_raddr", {reg1_raddr, reg2_raddr}, {if_inst[19:15], if_inst[24:20]});
    @(posedge clk);
    if (rst) begin
      {m_valid, m_we, m_ld, m_ill, m_pc, m_inst, m_r1, m_r2, m_imm, m_waddr} = '0;
      m_known = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0;
      m_known = 1'b0;
    end else if (adv) begin
      m_valid = take;
      if (take) begin
        m_known = 1'b1;
        m_pc = if_pc; m_inst = if_inst; m_r1 = r1; m_r2 = r2; m_imm = d.imm;
        m_waddr = if_inst[11:7]; m_we = d.we; m_ld = d.ld; m_ill = d.ill;
      end else if (hz) m_we = 1'b0;
    end
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    if (m_known) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_inst", ex_inst, m_inst);
      chk("ex_reg1", ex_reg1, m_r1);
      chk("ex_reg2", ex_reg2, m_r2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_ctrl", {ex_waddr, ex_we, ex_is_load, ex_illegal}, {m_waddr, m_we, m_ld, m_ill});
    end
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    logic [6:0] ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
    w = $urandom;
    if ($urandom_range(0, 15) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    w[19:15] = 5'($urandom_range(0, 7));
    w[11:7] = 5'($urandom_range(0, 7));
    if (w[6:0] != 7'h13) w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
    return w;
  endfunction
  initial begin
    rst = 1'b1; if_valid = 0; if_pc = 0; if_inst = 0; reg1_rdata = 0; reg2_rdata = 0;
    fwd_we = 0; fwd_waddr = 0; fwd_wdata = 0; flush = 0; ex_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    {m_we, m_ld, m_ill, m_pc, m_inst, m_r1, m_r2, m_imm, m_waddr} = '0;
    m_known = 1'b1;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_fields", ex_pc | ex_inst | ex_reg1 | ex_reg2 | ex_imm, 0);
    chk("rst_ctrl", {ex_waddr, ex_we, ex_is_load, ex_illegal}, 0);
    cycle();
    rst = 0; if_valid = 1; if_pc = 32'h100; if_inst = 32'hFFB00093; reg1_rdata = 32'h1234;
    cycle();
    chk("addi_imm", ex_imm, 32'hFFFFFFFB);
    chk("addi_rd", {ex_valid, ex_we, ex_waddr}, {1'b1, 1'b1, 5'd1});
    chk("addi_reg1", ex_reg1, 0);
    if_inst = 32'h002081B3; if_pc = 32'h104; reg1_rdata = 32'h1111; fwd_we = 3'b011;
    fwd_waddr = {5'd0, 5'd1, 5'd1}; fwd_wdata = {32'h0, 32'hBBBB, 32'hAAAA};
    cycle();
    chk("fwd_prio", ex_reg1, 32'hAAAA);
    if_inst = 32'h002001B3; fwd_we = 3'b111; fwd_waddr = 0;
    cycle();
    chk("fwd_x0", ex_reg1, 0);
    if_inst = 32'h00012283; fwd_we = 0;
    cycle();
    if_inst = 32'h00528333;
    cycle();
    chk("lu_bubble", {ex_valid, ex_we}, 0);
    fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd5, 5'd0}; fwd_wdata = {32'h0, 32'h1234, 32'h0};
    cycle();
    chk("lu_fwd", {ex_reg1, ex_reg2}, {32'h1234, 32'h1234});
    fwd_we = 0; if_inst = 32'hFFB00093; ex_ready = 0;
    repeat (3) cycle();
    chk("stall_hold", ex_inst, 32'h00528333);
    ex_ready = 1;
    cycle();
    chk("stall_release", ex_inst, 32'hFFB00093);
    flush = 1;
    cycle();
    chk("flush", 32'(ex_valid), 0);
    flush = 0; ex_ready = 0;
    repeat (2) cycle();
    rst = 1;
    cycle();
    chk("rst_stall", {31'b0, ex_valid} | ex_pc | ex_inst, 0);
    rst = 0; ex_ready = 1; if_inst = 32'h0000007F;
    cycle();
    chk("ill_op", {ex_illegal, ex_we}, 2'b10);
    if_inst = 32'h40209133;
    cycle();
    chk("ill_f7", {ex_illegal, ex_we}, 2'b10);
    if_inst = 32'hFE000EE3;
    cycle();
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);
    for (int n = 0; n < 2000; n++) begin
      rst = $urandom_range(0, 99) == 0;
      flush = $urandom_range(0, 19) == 0;
      ex_ready = $urandom_range(0, 9) < 7;
      if_valid = $urandom_range(0, 9) < 8;
      if_pc = $urandom; if_inst = rnd_inst();
      reg1_rdata = $urandom; reg2_rdata = $urandom;
      fwd_we = 3'($urandom);
      for (int i = 0; i < 3; i++) fwd_waddr[i*5 +: 5] = 5'($urandom_range(0, 7));
      fwd_wdata = {$urandom, $urandom, $urandom};
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
